// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan controller: segment table,
// cathode bit positions and the supported digit-count limit.
package ssd_pkg;

    localparam int DIGITS_MAX = 8;
    localparam int IDX_W      = $clog2(DIGITS_MAX);

    // cath_n bit order is {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}
    localparam int CATH_A_BIT  = 7;
    localparam int CATH_G_BIT  = 1;
    localparam int CATH_DP_BIT = 0;

    typedef logic [6:0] seg_t;

    // abcdefg, 1 = lit, indexed by hex nibble
    localparam seg_t SEG_TABLE [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational hex nibble to abcdefg segment pattern (1 = lit).
module ssd_hex_decoder
    import ssd_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_TABLE[nibble];
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed seven-segment scan controller with frame-aligned input shadows,
// leading-zero blanking and PWM brightness. All outputs are registered.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int SCAN_DIV_BITS = 18,
    parameter int PWM_BITS      = 4
) (
    input  logic                    ClkPort,
    input  logic                    Reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    blank_lz,
    input  logic [PWM_BITS-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic [7:0]              cath_n,
    output logic                    frame_start
);

    logic [SCAN_DIV_BITS-1:0] presc_q, presc_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]  val_sh_q, val_sh_d;
    logic [NUM_DIGITS-1:0]    dp_sh_q, dp_sh_d;
    logic [NUM_DIGITS-1:0]    en_sh_q, en_sh_d;
    logic                     blz_sh_q, blz_sh_d;
    logic [NUM_DIGITS-1:0]    an_n_d;
    logic [7:0]               cath_n_d;
    logic                     frame_start_d;

    logic                capture;
    logic [3:0]          nibble;
    logic [6:0]          seg;
    logic                sel_dp, sel_en, upper_nz, blank, pwm_on, lit;
    logic [PWM_BITS-1:0] pwm_frac;

    ssd_hex_decoder u_dec (
        .nibble (nibble),
        .seg    (seg)
    );

    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (presc_q == '1) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end

        // Decisions in the capture cycle use the freshly sampled inputs so that
        // the first slot of every frame already shows the new data.
        capture  = (presc_q == '0) && (idx_q == '0);
        val_sh_d = capture ? value    : val_sh_q;
        dp_sh_d  = capture ? dp       : dp_sh_q;
        en_sh_d  = capture ? digit_en : en_sh_q;
        blz_sh_d = capture ? blank_lz : blz_sh_q;

        nibble   = '0;
        sel_dp   = 1'b0;
        sel_en   = 1'b0;
        upper_nz = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nibble = val_sh_d[4*i +: 4];
                sel_dp = dp_sh_d[i];
                sel_en = en_sh_d[i];
            end
            if ((IDX_W'(i) >= idx_q) && ((val_sh_d[4*i +: 4] != '0) || dp_sh_d[i])) begin
                upper_nz = 1'b1;
            end
        end

        blank    = blz_sh_d && (idx_q != '0) && !upper_nz;
        pwm_frac = presc_q[SCAN_DIV_BITS-1 -: PWM_BITS];
        pwm_on   = (brightness == '1) || (pwm_frac < brightness);
        lit      = sel_en && !blank && pwm_on;

        an_n_d   = '1;
        cath_n_d = '1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (lit && (idx_q == IDX_W'(i))) begin
                an_n_d[i] = 1'b0;
            end
        end
        if (lit) begin
            cath_n_d[CATH_A_BIT:CATH_G_BIT] = ~seg;
            cath_n_d[CATH_DP_BIT]           = ~sel_dp;
        end

        frame_start_d = capture;
    end

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            presc_q     <= '0;
            idx_q       <= '0;
            val_sh_q    <= '0;
            dp_sh_q     <= '0;
            en_sh_q     <= '0;
            blz_sh_q    <= 1'b0;
            an_n        <= '1;
            cath_n      <= '1;
            frame_start <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            val_sh_q    <= val_sh_d;
            dp_sh_q     <= dp_sh_d;
            en_sh_q     <= en_sh_d;
            blz_sh_q    <= blz_sh_d;
            an_n        <= an_n_d;
            cath_n      <= cath_n_d;
            frame_start <= frame_start_d;
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl: vector table, corner-case sequences and a random
// run against a frame/slot arithmetic model of the display.
module tb_ssd_scan_ctrl;

    logic        ClkPort = 1'b0;
    logic        Reset   = 1'b1;
    logic [15:0] value   = '0;
    logic [3:0]  dp      = '0;
    logic [3:0]  digit_en = '0;
    logic        blank_lz = 1'b0;
    logic [1:0]  brightness = '0;
    logic [3:0]  an_n;
    logic [7:0]  cath_n;
    logic        frame_start;

    logic [11:0] value3 = '0;
    logic [2:0]  dp3 = '0;
    logic [2:0]  en3 = '0;
    logic [2:0]  an3;
    logic [7:0]  cath3;
    logic        fs3;

    always #5 ClkPort = ~ClkPort;

    ssd_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV_BITS(4), .PWM_BITS(2)) dut (
        .ClkPort(ClkPort), .Reset(Reset), .value(value), .dp(dp),
        .digit_en(digit_en), .blank_lz(blank_lz), .brightness(brightness),
        .an_n(an_n), .cath_n(cath_n), .frame_start(frame_start)
    );

    ssd_scan_ctrl #(.NUM_DIGITS(3), .SCAN_DIV_BITS(4), .PWM_BITS(2)) dut3 (
        .ClkPort(ClkPort), .Reset(Reset), .value(value3), .dp(dp3),
        .digit_en(en3), .blank_lz(1'b0), .brightness(2'd3),
        .an_n(an3), .cath_n(cath3), .frame_start(fs3)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: time since reset release decides prescaler and slot.
    bit [6:0]    segs [16];
    int          m_t = 0;
    logic [15:0] sh_val;
    logic [3:0]  sh_dp, sh_en;
    logic        sh_blz;
    logic [3:0]  exp_an;
    logic [7:0]  exp_cath;
    logic        exp_fs;

    task automatic model_step();
        int presc, idx, f;
        logic [3:0] nib;
        bit blank, on, lit;
        if (Reset) begin
            m_t = 0; sh_val = '0; sh_dp = '0; sh_en = '0; sh_blz = 1'b0;
            exp_an = 4'hF; exp_cath = 8'hFF; exp_fs = 1'b0;
            return;
        end
        presc = m_t % 16;
        idx   = (m_t / 16) % 4;
        exp_fs = (m_t % 64) == 0;
        if (exp_fs) begin
            sh_val = value; sh_dp = dp; sh_en = digit_en; sh_blz = blank_lz;
        end
        nib   = 4'((sh_val >> (4 * idx)) & 16'hF);
        blank = sh_blz && idx > 0 && (sh_val >> (4 * idx)) == 0 && (sh_dp >> idx) == 0;
        f     = presc / 4;
        on    = (brightness == 3) || (f < int'(brightness));
        lit   = sh_en[idx] && !blank && on;
        exp_an   = lit ? ~(4'b0001 << idx) : 4'hF;
        exp_cath = lit ? {~segs[nib], ~sh_dp[idx]} : 8'hFF;
        m_t++;
    endtask

    // One clock: model predicts, edge happens, outputs sampled at negedge.
    task automatic cycle(input bit do_check);
        model_step();
        @(posedge ClkPort);
        @(negedge ClkPort);
        if (do_check) begin
            check("rand_an_n", 32'(an_n), 32'(exp_an));
            check("rand_cath_n", 32'(cath_n), 32'(exp_cath));
            check("rand_frame_start", 32'(frame_start), 32'(exp_fs));
        end
    endtask

    // Run until outputs reflect slot-time t (edges since release = t+1).
    task automatic run_to(input int t);
        int budget;
        budget = 0;
        while (m_t < t + 1 && budget < 5000) begin
            cycle(0);
            budget++;
        end
        if (budget >= 5000) check("run_to_budget", 32'(budget), 32'd0);
    endtask

    task automatic restart();
        Reset = 1'b1;
        cycle(0);
        Reset = 1'b0;
    endtask

    typedef struct {
        logic [15:0] val;
        logic [3:0]  dpv;
        logic [3:0]  en;
        logic        blz;
        logic [1:0]  br;
        int          t;
        logic [3:0]  an;
        logic [7:0]  cath;
    } vec_t;

    vec_t vecs [19];

    initial begin
        int cnt;
        logic [2:0] e3;

        segs = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

        vecs[0]  = '{16'h12AF, 4'h0, 4'hF, 1'b0, 2'd3,  5, 4'hE, 8'h71};
        vecs[1]  = '{16'h12AF, 4'h0, 4'hF, 1'b0, 2'd3, 16, 4'hD, 8'h11};
        vecs[2]  = '{16'h12AF, 4'h0, 4'hF, 1'b0, 2'd3, 47, 4'hB, 8'h25};
        vecs[3]  = '{16'h12AF, 4'h0, 4'hF, 1'b0, 2'd3, 55, 4'h7, 8'h9F};
        vecs[4]  = '{16'h0030, 4'h0, 4'hF, 1'b1, 2'd3, 51, 4'hF, 8'hFF};
        vecs[5]  = '{16'h0030, 4'h0, 4'hF, 1'b1, 2'd3, 40, 4'hF, 8'hFF};
        vecs[6]  = '{16'h0030, 4'h0, 4'hF, 1'b1, 2'd3, 20, 4'hD, 8'h0D};
        vecs[7]  = '{16'h0030, 4'h0, 4'hF, 1'b1, 2'd3,  2, 4'hE, 8'h03};
        vecs[8]  = '{16'h0030, 4'h8, 4'hF, 1'b1, 2'd3, 51, 4'h7, 8'h02};
        vecs[9]  = '{16'h0030, 4'h8, 4'hF, 1'b1, 2'd3, 40, 4'hB, 8'h03};
        vecs[10] = '{16'h12AF, 4'h0, 4'hF, 1'b0, 2'd1,  3, 4'hE, 8'h71};
        vecs[11] = '{16'h12AF, 4'h0, 4'hF, 1'b0, 2'd1,  4, 4'hF, 8'hFF};
        vecs[12] = '{16'h12AF, 4'h0, 4'hF, 1'b0, 2'd0, 16, 4'hF, 8'hFF};
        vecs[13] = '{16'h12AF, 4'h0, 4'hF, 1'b0, 2'd2, 39, 4'hB, 8'h25};
        vecs[14] = '{16'h12AF, 4'h0, 4'hF, 1'b0, 2'd2, 40, 4'hF, 8'hFF};
        vecs[15] = '{16'h12AF, 4'h0, 4'hB, 1'b0, 2'd3, 40, 4'hF, 8'hFF};
        vecs[16] = '{16'h12AF, 4'h4, 4'hF, 1'b0, 2'd3, 40, 4'hB, 8'h24};
        vecs[17] = '{16'h1000, 4'h0, 4'hF, 1'b1, 2'd3, 40, 4'hB, 8'h03};
        vecs[18] = '{16'h0000, 4'h0, 4'hF, 1'b1, 2'd3,  8, 4'hE, 8'h03};

        // Reset state
        Reset = 1'b1;
        repeat (3) cycle(0);
        check("reset_an_n", 32'(an_n), 32'hF);
        check("reset_cath_n", 32'(cath_n), 32'hFF);
        check("reset_frame_start", 32'(frame_start), 32'h0);
        check("reset_an3", 32'(an3), 32'h7);

        // Vector table
        foreach (vecs[i]) begin
            Reset = 1'b1;
            value = vecs[i].val; dp = vecs[i].dpv; digit_en = vecs[i].en;
            blank_lz = vecs[i].blz; brightness = vecs[i].br;
            cycle(0);
            Reset = 1'b0;
            run_to(vecs[i].t);
            check($sformatf("vec%0d_an_n", i), 32'(an_n), 32'(vecs[i].an));
            check($sformatf("vec%0d_cath_n", i), 32'(cath_n), 32'(vecs[i].cath));
        end

        // Duty cycle: lit cycles in slot 1 for each brightness
        for (int b = 0; b < 4; b++) begin
            value = 16'h12AF; dp = '0; digit_en = 4'hF; blank_lz = 1'b0;
            brightness = 2'(b);
            restart();
            run_to(15);
            cnt = 0;
            for (int t = 16; t < 32; t++) begin
                run_to(t);
                if (an_n != 4'hF) cnt++;
            end
            check($sformatf("duty_br%0d", b), 32'(cnt), (b == 3) ? 32'd16 : 32'(4 * b));
        end

        // Frame start every 64 cycles
        brightness = 2'd3;
        restart();
        cnt = 0;
        for (int t = 0; t < 192; t++) begin
            run_to(t);
            if (frame_start) begin
                cnt++;
                check("fs_position", 32'(t % 64), 32'd0);
            end
        end
        check("fs_count", 32'(cnt), 32'd3);

        // Mid-frame value change is held off until the next frame
        value = 16'h1111;
        restart();
        run_to(31);
        value = 16'h2222;
        run_to(32);
        check("tear_slot2_an", 32'(an_n), 32'hB);
        check("tear_slot2_cath", 32'(cath_n), 32'h9F);
        run_to(52);
        check("tear_slot3_cath", 32'(cath_n), 32'h9F);
        run_to(64);
        check("tear_fs", 32'(frame_start), 32'h1);
        check("tear_new_cath", 32'(cath_n), 32'h25);
        run_to(65);
        check("tear_fs_low", 32'(frame_start), 32'h0);

        // Asynchronous reset during slot 2, then fresh capture
        value = 16'h12AF;
        restart();
        run_to(36);
        check("arst_pre_an", 32'(an_n), 32'hB);
        #2 Reset = 1'b1;
        #1;
        check("arst_an_n", 32'(an_n), 32'hF);
        check("arst_cath_n", 32'(cath_n), 32'hFF);
        @(negedge ClkPort);
        cycle(0);
        value = 16'h00B5;
        Reset = 1'b0;
        run_to(0);
        check("arst_first_an", 32'(an_n), 32'hE);
        check("arst_first_cath", 32'(cath_n), 32'h49);
        check("arst_first_fs", 32'(frame_start), 32'h1);

        // Three-digit instance: index wraps at 3, frame every 48 cycles
        en3 = 3'b111; value3 = 12'h321;
        restart();
        cnt = 0;
        for (int t = 0; t < 96; t++) begin
            run_to(t);
            if (fs3) begin
                cnt++;
                check("d3_fs_position", 32'(t % 48), 32'd0);
            end
            if (t % 16 == 8) begin
                e3 = ~(3'b001 << ((t / 16) % 3));
                check("d3_index_an", 32'(an3), 32'(e3));
            end
        end
        check("d3_fs_count", 32'(cnt), 32'd2);
        en3 = 3'b010;
        restart();
        for (int t = 0; t < 96; t++) begin
            run_to(t);
            if (t % 16 == 8) begin
                e3 = (((t / 16) % 3) == 1) ? 3'b101 : 3'b111;
                check("d3_en_an", 32'(an3), 32'(e3));
            end
        end

        // Random run against the model
        restart();
        for (int n = 0; n < 4000; n++) begin
            if (Reset) begin
                if ($urandom_range(0, 1) == 0) Reset = 1'b0;
            end else if ($urandom_range(0, 599) == 0) begin
                Reset = 1'b1;
            end
            if ($urandom_range(0, 29) == 0) begin
                case ($urandom_range(0, 4))
                    0: value = 16'($urandom);
                    1: value = 16'($urandom) & 16'h0FFF;
                    2: value = 16'($urandom) & 16'h00FF;
                    3: value = 16'($urandom) & 16'h000F;
                    default: value = '0;
                endcase
                dp = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
                digit_en = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
                blank_lz = 1'($urandom);
            end
            if ($urandom_range(0, 19) == 0) brightness = 2'($urandom);
            cycle(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ssd_scan_ctrl.md
SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 8, number of multiplexed seven-segment digits (legal 1..8).
REQ-002 Parameter SCAN_DIV_BITS, default 18, log2 of ClkPort cycles per digit slot (2^18 gives 381 Hz per digit at 100 MHz).
REQ-003 Parameter PWM_BITS, default 4, brightness resolution (legal 1..SCAN_DIV_BITS).
REQ-004 ClkPort  input  1  system clock, 100 MHz.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 value  input  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i; digit 0 is least significant.
REQ-007 dp  input  NUM_DIGITS  decimal point per digit, 1 = lit.
REQ-008 digit_en  input  NUM_DIGITS  per-digit enable, 0 = digit dark.
REQ-009 blank_lz  input  1  1 = suppress leading zeros.
REQ-010 brightness  input  PWM_BITS  duty control: 0 = off; all-ones = 100%.
REQ-011 an_n  output  NUM_DIGITS  anode selects, active-low, registered.
REQ-012 cath_n  output  8  {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low, registered.
REQ-013 frame_start  output  1  one-cycle pulse per scan frame, registered.

Function
REQ-014 Prescaler: SCAN_DIV_BITS-bit up-counter, increments every cycle and wraps from all-ones to 0.
REQ-015 Digit index: advances by 1 on each prescaler wrap, wraps from NUM_DIGITS-1 to 0 (not to a power of two).
REQ-016 Shadow capture: value, dp, digit_en and blank_lz are sampled into shadow registers in every cycle where prescaler==0 and index==0, including the first cycle after Reset deasserts; all display decisions use shadows only, so input changes mid-frame never tear.
REQ-017 frame_start is high for exactly the one cycle after each shadow capture.
REQ-018 Segment encoding (abcdefg, 1 = lit): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111; cath_n is the bitwise inverse with Dp = ~dp[index].
REQ-019 Leading-zero blank: digit i (i>0) is blank when blank_lz=1, every shadow nibble i..NUM_DIGITS-1 is 0, and shadow dp[i..NUM_DIGITS-1] are all 0; digit 0 is never blanked by this rule.
REQ-020 Blanked or disabled digit: an_n all ones and cath_n all ones for that slot.
REQ-021 PWM: with f = prescaler[SCAN_DIV_BITS-1 : SCAN_DIV_BITS-PWM_BITS], the selected anode is driven low only when brightness is all-ones or f < brightness; otherwise an_n is all ones.
REQ-022 brightness is sampled live (not shadowed); a change takes effect within 1 cycle.
REQ-023 At most one an_n bit is low in any cycle; cath_n is all ones whenever an_n is all ones.
REQ-024 Output latency: an_n/cath_n reflect the prescaler/index state of the previous cycle (1 register stage).

Reset
REQ-025 While Reset=1: prescaler=0, index=0, shadows=0, an_n=all ones, cath_n=8'hFF, frame_start=0.
REQ-026 Reset asserted mid-frame takes effect immediately (asynchronous); scanning restarts at digit 0 with a fresh capture on release.

Structure
REQ-027 Package ssd_pkg holds the 16-entry segment table, cathode bit-order constants and the DIGITS_MAX=8 limit.
REQ-028 One sub-module, ssd_hex_decoder (combinational nibble-to-abcdefg using ssd_pkg), is instantiated once on the index-muxed nibble.

Verification (NUM_DIGITS=4, SCAN_DIV_BITS=4, PWM_BITS=2 unless stated)
REQ-029 value=16'h12AF, dp=0, digit_en=4'hF, brightness=3 -> an_n cycles 1110,1101,1011,0111, 16 cycles each; cath_n = 8'h71,8'h11,8'h25,8'h9F respectively; frame_start every 64 cycles.
REQ-030 value=16'h0030, blank_lz=1 -> digits 3 and 2 dark (an_n 1111 in their slots); digit 1 shows 3 (8'h0D), digit 0 shows 0 (8'h03); with dp[3]=1, digit 3 shows 0 with Dp lit (8'h02) and digit 2 also shows 0.
REQ-031 brightness=1 -> anode low for 4 of 16 cycles per slot; brightness=0 -> an_n never low; brightness=3 -> low all 16 cycles.
REQ-032 value changed from 16'h1111 to 16'h2222 in slot 2 -> slots 2,3 still show 1; 2 appears from the next frame_start.
REQ-033 NUM_DIGITS=3 -> index sequence 0,1,2,0; an_n width 3; frame every 48 cycles; digit_en=3'b010 -> only digit 1 lit.
REQ-034 Reset pulsed during slot 2 -> an_n=1s, cath_n=8'hFF immediately; after release, first lit slot is digit 0 with freshly captured value.
